fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch stage upstream of the single-cycle core. Owns the fetch PC and drives a
//  synchronous-read instruction memory (1-cycle latency). Buffers fetched words with their PC in
//  a small prefetch FIFO and hands them to the core over a valid/ready handshake.
//  Branch/jump redirects from the core flush the FIFO and restart fetch at a new word address.
// PARAMETERS
//  PC_W      10  word-address width; 2^PC_W words of instruction memory
//  DEPTH     4   prefetch FIFO entries; power of 2, >= 2
//  RESET_PC  0   word address fetched first after reset
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     reset; asynchronous, active-high
//  imem_req     out  1     read request to instruction memory this cycle
//  imem_addr    out  PC_W  word address of the request
//  imem_rdata   in   32    read data; valid exactly 1 cycle after imem_req
//  redirect     in   1     flush and restart fetch (branch/jump taken)
//  redirect_pc  in   PC_W  new fetch word address, sampled when redirect=1
//  inst_valid   out  1     FIFO head holds a valid instruction
//  inst_ready   in   1     core accepts head this cycle
//  inst         out  32    head instruction word
//  inst_pc      out  PC_W  word address of head instruction
// BEHAVIOUR
//  - Reset (async, while rst=1): fetch_pc=RESET_PC, FIFO empty, in-flight flag 0; outputs
//    imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
//  - inst/inst_pc are forced to 0 whenever the FIFO is empty.
//  - Request: imem_req=1 iff !rst && !redirect && (occupancy + inflight) < DEPTH. On request,
//    imem_addr=fetch_pc and fetch_pc <= fetch_pc+1, wrapping 2^PC_W-1 -> 0 (mod 2^PC_W).
//  - Response: cycle after an unflushed request, {addr, imem_rdata} is pushed at that edge.
//  - Latency: req in cycle N -> data captured end of N+1 -> inst_valid=1 in N+2.
//  - Pop: on inst_valid && inst_ready at an edge; next entry (if any) presented next cycle.
//    inst_ready while inst_valid=0 has no effect.
//  - Credit rule: occupancy+inflight never exceeds DEPTH; push and pop in the same cycle are
//    both performed, including at full. With inst_ready held 1, throughput is 1 instr/cycle.
//  - Redirect (cycle R): a handshake completing in R counts as accepted; at the edge ending R
//    the FIFO is emptied, the in-flight response is discarded, fetch_pc <= redirect_pc.
//    No request in R; request for redirect_pc in R+1; inst_valid=0 in R+1 and R+2,
//    inst_valid=1 with inst_pc=redirect_pc in R+3. Back-to-back redirects: last one wins.
//  - Reset asserted mid-operation discards FIFO and in-flight data immediately.
//  - inst_valid, once high, stays high with stable inst/inst_pc until popped or redirected.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds output port perf_count [31:0], reset 0, incremented by 1 on every
//    completed inst handshake, wraps at 2^32; redirect does not clear it.
//  FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset release, imem holds mem[i]=i, inst_ready=1 -> pc 0,1,2,... delivered from cycle 2,
//     one per cycle, inst==inst_pc, no gaps.
//  2. inst_ready=0 for 10 cycles after reset -> exactly DEPTH (4) entries buffered, imem_req=0
//     once credits exhausted; release -> pcs 0..3 then 4.. in order, none lost or duplicated.
//  3. Redirect with redirect_pc=0x200 while FIFO holds 3 entries -> those dropped, imem_addr=0x200
//     in R+1, first delivered inst_pc=0x200 in R+3.
//  4. RESET_PC=0x3FE, inst_ready=1 -> inst_pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
//  5. Redirect in same cycle as an in-flight response and a pop -> pop accepted, response never
//     appears at output; two consecutive redirects 0x10 then 0x20 -> first inst_pc=0x20.
//  6. FETCH_PERF_EN defined, 7 handshakes with a redirect between -> perf_count=7; assert rst
//     mid-stream -> perf_count=0, inst_valid=0 immediately.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, synchronous imem requester and prefetch FIFO with redirect flush.
// Define FETCH_PERF_EN to add perf_count, a wrapping count of accepted instructions.
module fetch_queue #(
    parameter int unsigned     PC_W     = 10,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_count
`endif
);

    localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PC_W-1:0] fetchPc;
    logic            inflight;
    logic [PC_W-1:0] inflightPc;
    logic [AW-1:0]   rdPtr;
    logic [AW-1:0]   wrPtr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   creditUsed;
    logic            push;
    logic            pop;
    logic            empty;
    logic [31:0]     instMem [DEPTH];
    logic [PC_W-1:0] pcMem   [DEPTH];

    // Credits cover both buffered entries and the one response still in flight.
    assign empty      = (count == '0);
    assign creditUsed = count + CW'(inflight);
    assign imem_req   = !rst && !redirect && (creditUsed < DEPTH_C);
    assign imem_addr  = fetchPc;

    assign push       = inflight && !redirect;
    assign pop        = !empty && inst_ready;

    assign inst_valid = !empty;
    assign inst       = empty ? '0 : instMem[rdPtr];
    assign inst_pc    = empty ? '0 : pcMem[rdPtr];

    // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
        end else if (redirect) begin
            // A pop in this cycle is still accepted; everything behind it is dropped.
            fetchPc  <= redirect_pc;
            inflight <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetchPc    <= fetchPc + PC_W'(1);
                inflightPc <= fetchPc;
            end
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: entry storage is deliberately not reset; occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            instMem[wrPtr] <= imem_rdata;
            pcMem[wrPtr]   <= inflightPc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      perf_count <= '0;
        else if (pop) perf_count <= perf_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic against a transaction-queue model.
// Build with FETCH_PERF_EN defined to also exercise perf_count.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int PC_W  = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            imemReq, imemReqW;
    logic [PC_W-1:0] imemAddr, imemAddrW;
    logic [31:0]     imemRdata, imemRdataW;
    logic            redirect;
    logic [PC_W-1:0] redirectPc;
    logic            instValid, instValidW;
    logic            instReady;
    logic [31:0]     inst, instW;
    logic [PC_W-1:0] instPc, instPcW;
    logic            readyW = 1'b1;
    logic            redirectW = 1'b0;
    logic [PC_W-1:0] redirectPcW = '0;
`ifdef FETCH_PERF_EN
    logic [31:0]     perfCount, perfCountW;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit identMem = 1'b0;

    typedef struct {
        logic [PC_W-1:0] pc;
        int              cyc;
    } req_t;

    fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(10'h000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(imemRdata),
        .redirect(redirect), .redirect_pc(redirectPc),
        .inst_valid(instValid), .inst_ready(instReady), .inst(inst), .inst_pc(instPc)
`ifdef FETCH_PERF_EN
        , .perf_count(perfCount)
`endif
    );

    fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(10'h3FE)) dutWrap (
        .clk(clk), .rst(rst),
        .imem_req(imemReqW), .imem_addr(imemAddrW), .imem_rdata(imemRdataW),
        .redirect(redirectW), .redirect_pc(redirectPcW),
        .inst_valid(instValidW), .inst_ready(readyW), .inst(instW), .inst_pc(instPcW)
`ifdef FETCH_PERF_EN
        , .perf_count(perfCountW)
`endif
    );

    function automatic logic [31:0] memWord(input logic [PC_W-1:0] a);
        if (identMem) return 32'(a);
        return {a, a[5:0], 16'h0000} ^ 32'h5A3C_96E1;
    endfunction

    // Synchronous-read instruction memories; garbage on cycles without a request.
    always @(posedge clk) imemRdata  <= imemReq  ? memWord(imemAddr)  : $urandom();
    always @(posedge clk) imemRdataW <= imemReqW ? memWord(imemAddrW) : $urandom();

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the caller at posedge+1 of cycle 0, the first cycle out of reset.
    task automatic doReset(input bit rdy);
        rst = 1'b1; redirect = 1'b0; redirectPc = '0; instReady = rdy;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; instReady = 1'b1;
        @(posedge clk); #2;
        vectors++; if (imemReq !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imemReq); end
        vectors++; if (imemAddr !== 10'h000) begin miscompares++; $display("FAIL reset_addr: got %h want 000", imemAddr); end
        vectors++; if (imemAddrW !== 10'h3FE) begin miscompares++; $display("FAIL reset_addr_wrap: got %h want 3fe", imemAddrW); end
        vectors++; if (instValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instValid); end
        vectors++; if (inst !== 32'h0 || instPc !== '0) begin miscompares++; $display("FAIL reset_head: got %h/%h want 0/0", inst, instPc); end
`ifdef FETCH_PERF_EN
        vectors++; if (perfCount !== 32'h0) begin miscompares++; $display("FAIL reset_perf: got %0d want 0", perfCount); end
`endif
    endtask

    task automatic test_stream();
        identMem = 1'b1;
        doReset(1'b1);
        for (int c = 0; c < 12; c++) begin
            #1;
            vectors++;
            if (imemReq !== 1'b1 || imemAddr !== PC_W'(c)) begin
                miscompares++; $display("FAIL stream_req c%0d: got %b/%h want 1/%h", c, imemReq, imemAddr, PC_W'(c));
            end
            vectors++;
            if (c >= 2) begin
                if (instValid !== 1'b1 || instPc !== PC_W'(c - 2) || inst !== 32'(c - 2)) begin
                    miscompares++; $display("FAIL stream_out c%0d: got v%b pc%h i%h want v1 pc%h", c, instValid, instPc, inst, PC_W'(c - 2));
                end
            end else if (instValid !== 1'b0 || inst !== 32'h0 || instPc !== '0) begin
                miscompares++; $display("FAIL stream_empty c%0d: got v%b pc%h i%h want all 0", c, instValid, instPc, inst);
            end
            @(posedge clk); #1;
        end
        identMem = 1'b0;
    endtask

    task automatic test_backpressure();
        int reqs;
        logic [PC_W-1:0] exp;
        identMem = 1'b0;
        doReset(1'b0);
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (imemReq === 1'b1) reqs++;
            vectors++;
            if (imemReq !== (c < DEPTH)) begin miscompares++; $display("FAIL bp_req c%0d: got %b want %b", c, imemReq, c < DEPTH); end
            if (c == 9) begin
                vectors++;
                if (instValid !== 1'b1 || instPc !== '0) begin miscompares++; $display("FAIL bp_head: got v%b pc%h want v1 pc000", instValid, instPc); end
            end
            @(posedge clk); #1;
        end
        vectors++; if (reqs !== DEPTH) begin miscompares++; $display("FAIL bp_credits: got %0d reqs want %0d", reqs, DEPTH); end
        instReady = 1'b1;
        exp = '0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (instValid === 1'b1) begin
                vectors++;
                if (instPc !== exp || inst !== memWord(exp)) begin
                    miscompares++; $display("FAIL bp_order: got pc%h i%h want pc%h i%h", instPc, inst, exp, memWord(exp));
                end
                exp++;
            end
            @(posedge clk); #1;
        end
        vectors++; if (exp !== PC_W'(16)) begin miscompares++; $display("FAIL bp_drain: got %0d pops want 16", exp); end
    endtask

    task automatic test_redirect();
        identMem = 1'b0;
        doReset(1'b0);
        repeat (4) begin @(posedge clk); #1; end
        redirect = 1'b1; redirectPc = 10'h200; #1;
        vectors++; if (imemReq !== 1'b0) begin miscompares++; $display("FAIL redir_req_R: got %b want 0", imemReq); end
        vectors++; if (instValid !== 1'b1 || instPc !== '0) begin miscompares++; $display("FAIL redir_head_R: got v%b pc%h want v1 pc000", instValid, instPc); end
        @(posedge clk); #1; redirect = 1'b0; redirectPc = 10'h155; #1;
        vectors++; if (imemReq !== 1'b1 || imemAddr !== 10'h200) begin miscompares++; $display("FAIL redir_req_R1: got %b/%h want 1/200", imemReq, imemAddr); end
        vectors++; if (instValid !== 1'b0) begin miscompares++; $display("FAIL redir_valid_R1: got %b want 0", instValid); end
        @(posedge clk); #2;
        vectors++; if (instValid !== 1'b0 || imemAddr !== 10'h201) begin miscompares++; $display("FAIL redir_R2: got v%b a%h want v0 a201", instValid, imemAddr); end
        @(posedge clk); #1; instReady = 1'b1; #1;
        vectors++;
        if (instValid !== 1'b1 || instPc !== 10'h200 || inst !== memWord(10'h200)) begin
            miscompares++; $display("FAIL redir_R3: got v%b pc%h i%h want v1 pc200", instValid, instPc, inst);
        end
        @(posedge clk); #2;
        vectors++; if (instValid !== 1'b1 || instPc !== 10'h201) begin miscompares++; $display("FAIL redir_R4: got v%b pc%h want v1 pc201", instValid, instPc); end
        instReady = 1'b0;
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] e;
        doReset(1'b1);
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 1) begin
                vectors++; if (imemAddrW !== 10'h3FF) begin miscompares++; $display("FAIL wrap_addr c1: got %h want 3ff", imemAddrW); end
            end
            if (c == 2) begin
                vectors++; if (imemAddrW !== 10'h000) begin miscompares++; $display("FAIL wrap_addr c2: got %h want 000", imemAddrW); end
            end
            if (c >= 2) begin
                e = 10'h3FE + PC_W'(c - 2);
                vectors++;
                if (instValidW !== 1'b1 || instPcW !== e || instW !== memWord(e)) begin
                    miscompares++; $display("FAIL wrap_out c%0d: got v%b pc%h want v1 pc%h", c, instValidW, instPcW, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_race();
        identMem = 1'b0;
        doReset(1'b1);
        repeat (3) begin @(posedge clk); #1; end
        redirect = 1'b1; redirectPc = 10'h010; #1;
        vectors++; if (instValid !== 1'b1 || instPc !== 10'h001) begin miscompares++; $display("FAIL race_pop_R: got v%b pc%h want v1 pc001", instValid, instPc); end
        @(posedge clk); #1; redirectPc = 10'h020; #1;
        vectors++; if (instValid !== 1'b0 || imemReq !== 1'b0) begin miscompares++; $display("FAIL race_R1: got v%b r%b want 0/0", instValid, imemReq); end
        @(posedge clk); #1; redirect = 1'b0; redirectPc = 10'h010; #1;
        vectors++; if (imemReq !== 1'b1 || imemAddr !== 10'h020) begin miscompares++; $display("FAIL race_req: got %b/%h want 1/020", imemReq, imemAddr); end
        @(posedge clk); #2;
        vectors++; if (instValid !== 1'b0) begin miscompares++; $display("FAIL race_gap: got %b want 0", instValid); end
        @(posedge clk); #2;
        vectors++;
        if (instValid !== 1'b1 || instPc !== 10'h020 || inst !== memWord(10'h020)) begin
            miscompares++; $display("FAIL race_first: got v%b pc%h i%h want v1 pc020", instValid, instPc, inst);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        int pops;
        int budget;
        doReset(1'b1);
        #1;
        vectors++; if (perfCount !== 32'h0) begin miscompares++; $display("FAIL perf_start: got %0d want 0", perfCount); end
        @(posedge clk); #1;
        pops = 0; budget = 0;
        while (pops < 4 && budget < 20) begin
            #1; if (instValid === 1'b1 && instReady) pops++;
            @(posedge clk); #1; budget++;
        end
        instReady = 1'b0; redirect = 1'b1; redirectPc = 10'h055;
        @(posedge clk); #1; redirect = 1'b0; instReady = 1'b1;
        budget = 0;
        while (pops < 7 && budget < 20) begin
            #1; if (instValid === 1'b1 && instReady) pops++;
            @(posedge clk); #1; budget++;
        end
        instReady = 1'b0; #1;
        vectors++; if (pops !== 7) begin miscompares++; $display("FAIL perf_budget: got %0d handshakes want 7", pops); end
        vectors++; if (perfCount !== 32'd7) begin miscompares++; $display("FAIL perf_count: got %0d want 7", perfCount); end
        instReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        #1;
        vectors++; if (instValid !== 1'b1) begin miscompares++; $display("FAIL perf_midstream: got %b want 1", instValid); end
        rst = 1'b1; #1;
        vectors++;
        if (instValid !== 1'b0 || perfCount !== 32'h0 || imemReq !== 1'b0) begin
            miscompares++; $display("FAIL perf_async_rst: got v%b p%0d r%b want 0/0/0", instValid, perfCount, imemReq);
        end
    endtask
`endif

    task automatic test_random();
        req_t q[$];
        logic [PC_W-1:0] expFetch;
        logic [31:0] expPerf;
        bit expReq;
        bit expValid;
        identMem = 1'b0;
        doReset(1'b0);
        expFetch = 10'h000;
        expPerf = '0;
        for (int c = 0; c < 3000; c++) begin
            instReady = (c % 400 < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            redirect = ($urandom_range(19) == 0);
            redirectPc = ($urandom_range(3) == 0) ? PC_W'(1020 + $urandom_range(3)) : PC_W'($urandom());
            #1;
            expReq = !redirect && (q.size() < DEPTH);
            expValid = (q.size() > 0) && (q[0].cyc + 2 <= c);
            vectors++;
            if (imemReq !== expReq) begin miscompares++; $display("FAIL rnd_req c%0d: got %b want %b", c, imemReq, expReq); end
            if (expReq) begin
                vectors++;
                if (imemAddr !== expFetch) begin miscompares++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imemAddr, expFetch); end
            end
            vectors++;
            if (instValid !== expValid) begin miscompares++; $display("FAIL rnd_valid c%0d: got %b want %b", c, instValid, expValid); end
            vectors++;
            if (expValid) begin
                if (instPc !== q[0].pc || inst !== memWord(q[0].pc)) begin
                    miscompares++; $display("FAIL rnd_head c%0d: got pc%h i%h want pc%h i%h", c, instPc, inst, q[0].pc, memWord(q[0].pc));
                end
            end else if (instPc !== '0 || inst !== 32'h0) begin
                miscompares++; $display("FAIL rnd_zero c%0d: got pc%h i%h want 0/0", c, instPc, inst);
            end
`ifdef FETCH_PERF_EN
            vectors++;
            if (perfCount !== expPerf) begin miscompares++; $display("FAIL rnd_perf c%0d: got %0d want %0d", c, perfCount, expPerf); end
`endif
            if (expValid && instReady) begin
                void'(q.pop_front());
                expPerf++;
            end
            if (redirect) begin
                q.delete();
                expFetch = redirectPc;
            end else if (expReq) begin
                q.push_back('{expFetch, c});
                expFetch++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirectPc = '0; instReady = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_redirect_race();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
